// File: rtl/hazard_forward_unit_if.sv
// Decode/forwarding bus between the pipeline control and the hazard/forward unit.
interface hazard_forward_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NRD    = 2
);
  logic                    id_we;
  logic [ADDR_W-1:0]       id_waddr;
  logic                    id_is_load;
  logic                    flush;
  logic [NRD-1:0]          rd_en;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rf_rdata;
  logic [DEPTH*DATA_W-1:0] st_wdata;
  logic [NRD*DATA_W-1:0]   fwd_rdata;
  logic                    stall;
  logic                    wb_we;
  logic [ADDR_W-1:0]       wb_waddr;
  logic [15:0]             stall_cnt;

  modport master (
    output id_we, id_waddr, id_is_load, flush, rd_en, rd_addr, rf_rdata, st_wdata,
    input  fwd_rdata, stall, wb_we, wb_waddr, stall_cnt
  );

  modport slave (
    input  id_we, id_waddr, id_is_load, flush, rd_en, rd_addr, rf_rdata, st_wdata,
    output fwd_rdata, stall, wb_we, wb_waddr, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Tracks destination registers of in-flight instructions, resolves operand
// forwarding per read port and raises a load-use stall.
module hazard_forward_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned NRD        = 2,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_unit_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              is_load;
  } stage_t;

  stage_t            r_stage [DEPTH];
  logic [15:0]       r_stall_cnt;

  logic [DEPTH-1:0]  w_live;
  logic [DEPTH-1:0]  w_ready;
  logic              w_stall;
  logic [NRD*DATA_W-1:0] w_fwd;
  logic              w_hit;
  logic              w_rdy;
  logic [DATA_W-1:0] w_hdata;
  logic [ADDR_W-1:0] w_addr;
  stage_t            w_id_rec;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage_flags
    assign w_live[k]  = r_stage[k].valid && r_stage[k].we && (r_stage[k].waddr != '0);
    assign w_ready[k] = !r_stage[k].is_load || (k >= LOAD_STAGE);
  end

  // Per port: scan oldest to youngest so the youngest live match wins.
  always_comb begin
    w_stall = 1'b0;
    w_fwd   = '0;
    w_hit   = 1'b0;
    w_rdy   = 1'b0;
    w_hdata = '0;
    w_addr  = '0;
    for (int i = 0; i < NRD; i++) begin
      w_addr  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      w_hit   = 1'b0;
      w_rdy   = 1'b0;
      w_hdata = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (w_live[k] && (r_stage[k].waddr == w_addr)) begin
          w_hit   = 1'b1;
          w_rdy   = w_ready[k];
          w_hdata = bus.st_wdata[k*DATA_W +: DATA_W];
        end
      end
      if (bus.rd_en[i] && (w_addr != '0)) begin
        if (w_hit && !w_rdy) begin
          w_stall = 1'b1;
        end
        w_fwd[i*DATA_W +: DATA_W] = (w_hit && w_rdy) ? w_hdata
                                                     : bus.rf_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stall or flush inserts a bubble at stage 0; older stages keep draining.
  always_comb begin
    w_id_rec = '0;
    if (!w_stall && !bus.flush) begin
      w_id_rec.valid   = 1'b1;
      w_id_rec.we      = bus.id_we;
      w_id_rec.waddr   = bus.id_waddr;
      w_id_rec.is_load = bus.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= w_id_rec;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.fwd_rdata = w_fwd;
  assign bus.stall     = w_stall;
  assign bus.wb_we     = w_live[DEPTH-1];
  assign bus.wb_waddr  = r_stage[DEPTH-1].waddr;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding, load-use stall, flush,
// reset behaviour and stall counter saturation.
module tb_hazard_forward_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  hazard_forward_unit_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(3),  .NRD(2)) bus  ();
  hazard_forward_unit_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NRD(1)) bus2 ();

  hazard_forward_unit #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(3), .NRD(2), .LOAD_STAGE(1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  hazard_forward_unit #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(32), .NRD(1), .LOAD_STAGE(31)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic we, input logic [4:0] waddr, input logic ld);
    bus.id_we      = we;
    bus.id_waddr   = waddr;
    bus.id_is_load = ld;
  endtask

  int n_st;
  int cyc;
  bit pre_done;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    id_set(1'b0, 5'd0, 1'b0);
    bus.flush    = 1'b0;
    bus.st_wdata = '0;
    bus.rf_rdata = {32'h0000_0222, 32'h0000_0111};
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {5'd2, 5'd1};
    bus2.id_we      = 1'b1;
    bus2.id_waddr   = 5'd5;
    bus2.id_is_load = 1'b1;
    bus2.flush      = 1'b0;
    bus2.rd_en      = 1'b1;
    bus2.rd_addr    = 5'd5;
    bus2.rf_rdata   = 32'h0;
    bus2.st_wdata   = '0;
    #2;
    // Reset state
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
    chk("rst_wb_waddr", 32'(bus.wb_waddr), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_fwd0", bus.fwd_rdata[31:0], 32'h111);
    chk("rst_fwd1", bus.fwd_rdata[63:32], 32'h222);
    bus.rd_en = 2'b01;
    #1 chk("gate_en_fwd1", bus.fwd_rdata[63:32], 32'h0);
    bus.rd_addr[4:0] = 5'd0;
    #1 chk("gate_r0_fwd0", bus.fwd_rdata[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU write r3 forwarded from EX, then MEM, then commit
    bus.rd_en = 2'b00;
    id_set(1'b1, 5'd3, 1'b0);
    tick();
    id_set(1'b0, 5'd0, 1'b0);
    bus.rd_en   = 2'b11;
    bus.rd_addr = {5'd9, 5'd3};
    bus.st_wdata[31:0] = 32'h1234;
    #1;
    chk("alu_fwd_ex", bus.fwd_rdata[31:0], 32'h1234);
    chk("alu_stall", 32'(bus.stall), 32'd0);
    chk("nomatch_rf", bus.fwd_rdata[63:32], 32'h222);
    tick();
    bus.st_wdata[63:32] = 32'h5555;
    #1 chk("alu_fwd_mem", bus.fwd_rdata[31:0], 32'h5555);
    tick();
    chk("wb_we_r3", 32'(bus.wb_we), 32'd1);
    chk("wb_waddr_r3", 32'(bus.wb_waddr), 32'd3);
    tick();
    chk("wb_we_empty", 32'(bus.wb_we), 32'd0);

    // Load-use on r5: one stall cycle then forward from stage 1
    bus.rd_en = 2'b00;
    id_set(1'b1, 5'd5, 1'b1);
    tick();
    id_set(1'b0, 5'd0, 1'b0);
    bus.rd_en = 2'b01;
    bus.rd_addr[4:0] = 5'd5;
    #1 chk("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.st_wdata[63:32] = 32'hBEEF;
    #1;
    chk("lu_release", 32'(bus.stall), 32'd0);
    chk("lu_fwd", bus.fwd_rdata[31:0], 32'hBEEF);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);

    // Older ready ALU r6 must not mask younger load r6
    bus.rd_en = 2'b00;
    id_set(1'b1, 5'd6, 1'b0);
    tick();
    id_set(1'b1, 5'd6, 1'b1);
    tick();
    id_set(1'b0, 5'd0, 1'b0);
    bus.rd_en = 2'b01;
    bus.rd_addr[4:0] = 5'd6;
    #1 chk("mask_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.st_wdata[63:32] = 32'h6161;
    bus.st_wdata[95:64] = 32'h6262;
    #1;
    chk("mask_release", 32'(bus.stall), 32'd0);
    chk("mask_fwd", bus.fwd_rdata[31:0], 32'h6161);
    chk("mask_cnt", 32'(bus.stall_cnt), 32'd2);

    // r7 live in stages 0 and 2: youngest wins
    bus.rd_en = 2'b00;
    tick(); tick(); tick();
    id_set(1'b1, 5'd7, 1'b0);
    tick();
    id_set(1'b1, 5'd8, 1'b0);
    tick();
    id_set(1'b1, 5'd7, 1'b0);
    tick();
    id_set(1'b0, 5'd0, 1'b0);
    bus.st_wdata = {32'hB, 32'h99, 32'hA};
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {5'd8, 5'd7};
    #1;
    chk("young_fwd0", bus.fwd_rdata[31:0], 32'hA);
    chk("young_fwd1", bus.fwd_rdata[63:32], 32'h99);
    chk("young_stall", 32'(bus.stall), 32'd0);
    chk("young_wb_waddr", 32'(bus.wb_waddr), 32'd7);

    // Write to r0 never forwards or commits
    bus.rd_en = 2'b00;
    id_set(1'b1, 5'd0, 1'b0);
    tick();
    id_set(1'b0, 5'd0, 1'b0);
    bus.rd_en = 2'b01;
    bus.rd_addr[4:0] = 5'd0;
    #1;
    chk("r0_fwd", bus.fwd_rdata[31:0], 32'h0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    tick(); tick();
    chk("r0_wb_we", 32'(bus.wb_we), 32'd0);

    // Flushed write to r4 never enters the pipeline
    bus.rd_en = 2'b00;
    id_set(1'b1, 5'd4, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    id_set(1'b0, 5'd0, 1'b0);
    bus.rd_en = 2'b01;
    bus.rd_addr[4:0] = 5'd4;
    #1 chk("flush_fwd_rf", bus.fwd_rdata[31:0], 32'h111);
    tick(); tick();
    chk("flush_wb_we", 32'(bus.wb_we), 32'd0);

    // Asynchronous reset in the middle of a stall
    bus.rd_en = 2'b00;
    id_set(1'b1, 5'd5, 1'b1);
    tick();
    id_set(1'b0, 5'd0, 1'b0);
    bus.rd_en = 2'b01;
    bus.rd_addr[4:0] = 5'd5;
    #1;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    chk("pre_rst_cnt", 32'(bus.stall_cnt), 32'd2);
    rst = 1'b0;
    #1;
    chk("async_rst_stall", 32'(bus.stall), 32'd0);
    chk("async_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_stall", 32'(bus.stall), 32'd0);
    chk("post_rst_fwd", bus.fwd_rdata[31:0], 32'h111);

    // Stall counter saturation on the deep-pipeline instance
    n_st     = 0;
    cyc      = 0;
    pre_done = 1'b0;
    while (n_st < 65540 && cyc < 90000) begin
      @(negedge clk);
      if (n_st == 65534 && !pre_done) begin
        chk("sat_pre", 32'(bus2.stall_cnt), 32'hFFFE);
        pre_done = 1'b1;
      end
      if (bus2.stall) n_st++;
      cyc++;
    end
    chk("sat_budget", 32'(n_st), 32'd65540);
    tick();
    chk("sat_cnt", 32'(bus2.stall_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 3, tracked stages after decode (stage 0 = EX, DEPTH-1 = WB).
REQ-004 SHALL have parameter NRD, default 2, number of register read ports served.
REQ-005 SHALL have parameter LOAD_STAGE, default 1, first stage index at which load data is valid (1..DEPTH-1).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port id_we  input  1  decode-stage instruction writes a register.
REQ-009 SHALL have port id_waddr  input  ADDR_W  decode-stage destination address.
REQ-010 SHALL have port id_is_load  input  1  decode-stage instruction is a load.
REQ-011 SHALL have port flush  input  1  kill decode-stage instruction this cycle.
REQ-012 SHALL have port rd_en  input  NRD  per-port read enable.
REQ-013 SHALL have port rd_addr  input  NRD*ADDR_W  per-port read address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 SHALL have port rf_rdata  input  NRD*DATA_W  register-file read data per port.
REQ-015 SHALL have port st_wdata  input  DEPTH*DATA_W  result data currently held in each stage, stage k at [k*DATA_W +: DATA_W].
REQ-016 SHALL have port fwd_rdata  output  NRD*DATA_W  resolved operand per port.
REQ-017 SHALL have port stall  output  1  load-use hazard; decode and fetch must hold.
REQ-018 SHALL have port wb_we  output  1  commit write enable from stage DEPTH-1.
REQ-019 SHALL have port wb_waddr  output  ADDR_W  commit address from stage DEPTH-1.
REQ-020 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-021 SHALL keep per stage k a record {valid, we, waddr, is_load}; a record is live if valid && we && waddr != 0.
REQ-022 SHALL shift records k -> k+1 every rising edge; stage DEPTH-1 record is discarded.
REQ-023 SHALL load stage 0 with {1, id_we, id_waddr, id_is_load} when stall=0 and flush=0, else with a bubble (valid=0).
REQ-024 SHALL define record k ready when is_load=0, or k >= LOAD_STAGE.
REQ-025 SHALL, per port i (combinational), select the lowest-index live stage whose waddr equals rd_addr[i]; match in ready stage k -> fwd_rdata[i] = st_wdata[k]; no match -> rf_rdata[i].
REQ-026 SHALL force fwd_rdata[i] = 0 when rd_en[i]=0 or rd_addr[i]=0, regardless of matches.
REQ-027 SHALL assert stall combinationally when any enabled port's youngest matching live record is not ready; older ready matches SHALL NOT mask a younger unready one.
REQ-028 SHALL, while stall=1, continue advancing stages 1..DEPTH-1 so the load reaches LOAD_STAGE; stall SHALL drop without extra cycle once ready.
REQ-029 SHALL give flush priority over stall for stage 0 input (both yield bubble); stall output is still computed from current records.
REQ-030 SHALL drive wb_we = valid && we of stage DEPTH-1 and wb_waddr = its waddr; wb_we SHALL be 0 when waddr = 0.
REQ-031 SHALL increment stall_cnt on each rising edge with stall=1, saturating at 16'hFFFF (no wrap).
REQ-032 SHALL give zero-cycle forwarding latency (same-cycle combinational path from st_wdata/rf_rdata to fwd_rdata).

Reset
REQ-033 SHALL, while rst=0, asynchronously clear all stage valid bits, waddr, is_load and stall_cnt to 0.
REQ-034 SHALL yield after reset: stall=0, wb_we=0, wb_waddr=0, stall_cnt=0, fwd_rdata = rf_rdata gated per REQ-026.
REQ-035 SHALL, on reset asserted mid-stall, drop stall immediately and resume with empty pipeline on first edge after rst=1.

Verification
REQ-036 SHALL cover: ALU write r3, next cycle port0 reads r3, st_wdata[0]=0x1234 -> fwd_rdata[0]=0x1234, stall=0.
REQ-037 SHALL cover: load to r5 then immediate read r5 -> stall=1 exactly 1 cycle (LOAD_STAGE=1), then fwd_rdata = st_wdata[1], stall_cnt=1.
REQ-038 SHALL cover: r7 live in stages 0 and 2 with data 0xA/0xB -> fwd_rdata = 0xA (youngest wins).
REQ-039 SHALL cover: write to r0 followed by read r0 -> fwd_rdata=0, stall=0, wb_we=0 at WB.
REQ-040 SHALL cover: flush with id_we=1 r4 -> no r4 record enters; three cycles later wb_we=0; and 65540 forced stalls -> stall_cnt=0xFFFF.
REQ-041 SHALL cover: rst=0 pulse during stall -> stall=0 and stall_cnt=0 without a clock edge.
